// File: rtl/text_overlay_pkg.sv
// Shared definitions for the marquee text overlay: FSM state encoding and counter width helpers.
package text_overlay_pkg;

  localparam logic [0:0] ST_PAUSE  = 1'b0;
  localparam logic [0:0] ST_SCROLL = 1'b1;

  // Bits needed to hold 0..n-1; never below 1 so degenerate sizes still get a real register.
  function automatic int unsigned ctr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the scroll offset, which indexes bitmap columns 0..bmp_w-1.
  function automatic int unsigned off_width(input int unsigned bmp_w);
    return ctr_width(bmp_w);
  endfunction

endpackage

// File: rtl/text_overlay_marquee_ctrl.sv
// Pause/scroll state machine and frame counters for the marquee overlay.
// Blink counter and phase exist only when TEXT_OVERLAY_BLINK_EN is defined.
module text_overlay_marquee_ctrl
  import text_overlay_pkg::*;
#(
  parameter int unsigned BMP_W        = 46,
  parameter int unsigned SCROLL_DIV   = 4,
  parameter int unsigned PAUSE_FRAMES = 60,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_start,
  input  logic                          scroll_en,
  output logic [off_width(BMP_W)-1:0]   scroll_offset,
  output logic                          scroll_wrap
`ifdef TEXT_OVERLAY_BLINK_EN
  ,
  output logic                          blink_phase
`endif
);

  localparam int unsigned OW = off_width(BMP_W);
  localparam int unsigned PW = ctr_width(PAUSE_FRAMES);
  localparam int unsigned DW = ctr_width(SCROLL_DIV);

  if (SCROLL_DIV < 1 || PAUSE_FRAMES < 1 || BLINK_FRAMES < 1 || BMP_W < 1) begin : g_bad_param
    $error("text_overlay_marquee_ctrl: frame counts and BMP_W must be >= 1");
  end

  logic [0:0]    state;
  logic [PW-1:0] pause_cnt;
  logic [DW-1:0] div_cnt;
  logic          step;

  // A frame only counts while scrolling is enabled; otherwise everything holds.
  assign step = frame_start & scroll_en;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_PAUSE;
      pause_cnt     <= '0;
      div_cnt       <= '0;
      scroll_offset <= '0;
      scroll_wrap   <= 1'b0;
    end else begin
      scroll_wrap <= 1'b0;
      if (step) begin
        case (state)
          ST_PAUSE: begin
            if (pause_cnt == PW'(PAUSE_FRAMES - 1)) begin
              pause_cnt <= '0;
              state     <= ST_SCROLL;
            end else begin
              pause_cnt <= pause_cnt + PW'(1);
            end
          end
          default: begin
            if (div_cnt == DW'(SCROLL_DIV - 1)) begin
              div_cnt <= '0;
              if (scroll_offset == OW'(BMP_W - 1)) begin
                scroll_offset <= '0;
                scroll_wrap   <= 1'b1;
                state         <= ST_PAUSE;
              end else begin
                scroll_offset <= scroll_offset + OW'(1);
              end
            end else begin
              div_cnt <= div_cnt + DW'(1);
            end
          end
        endcase
      end
    end
  end

`ifdef TEXT_OVERLAY_BLINK_EN
  localparam int unsigned BW = ctr_width(BLINK_FRAMES);

  logic [BW-1:0] blink_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (step) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end
`endif

endmodule

// File: rtl/text_overlay_marquee.sv
// 1-bpp bitmap text overlay with horizontal marquee scroll, fed by VGA x/y counters.
// Optional blink gating is enabled by defining TEXT_OVERLAY_BLINK_EN.
module text_overlay_marquee
  import text_overlay_pkg::*;
#(
  parameter int unsigned              BMP_W        = 46,
  parameter int unsigned              BMP_H        = 9,
  parameter logic [BMP_W*BMP_H-1:0]   BITMAP       = '0,
  parameter int unsigned              ORIG_X_CELL  = 18,
  parameter int unsigned              ORIG_Y_CELL  = 12,
  parameter int unsigned              CELL_LOG2    = 3,
  parameter int unsigned              WIN_W        = 46,
  parameter int unsigned              SCROLL_DIV   = 4,
  parameter int unsigned              PAUSE_FRAMES = 60,
  parameter int unsigned              BLINK_FRAMES = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_start,
  input  logic                          scroll_en,
  input  logic [9:0]                    x,
  input  logic [9:0]                    y,
  output logic                          overlay_active,
  output logic [off_width(BMP_W)-1:0]   scroll_offset,
  output logic                          scroll_wrap
);

  if (WIN_W < 1 || WIN_W > BMP_W) begin : g_bad_win
    $error("text_overlay_marquee: WIN_W must be in 1..BMP_W");
  end

`ifdef TEXT_OVERLAY_BLINK_EN
  logic blink_phase;
`endif

  text_overlay_marquee_ctrl #(
    .BMP_W        (BMP_W),
    .SCROLL_DIV   (SCROLL_DIV),
    .PAUSE_FRAMES (PAUSE_FRAMES),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_ctrl (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start   (frame_start),
    .scroll_en     (scroll_en),
    .scroll_offset (scroll_offset),
    .scroll_wrap   (scroll_wrap)
`ifdef TEXT_OVERLAY_BLINK_EN
    ,
    .blink_phase   (blink_phase)
`endif
  );

  // Window arithmetic is carried at 32 bits so coordinates left of or above the origin never alias in.
  logic [31:0] xc, yc, c, r, col, idx;
  logic        in_win, bmp_bit, pixel_on;

  // NOTE: every combinational output gets a value on every path first, so no latch is inferred.
  always_comb begin
    xc      = 32'(x >> CELL_LOG2);
    yc      = 32'(y >> CELL_LOG2);
    in_win  = (xc >= ORIG_X_CELL) && (xc < ORIG_X_CELL + WIN_W) &&
              (yc >= ORIG_Y_CELL) && (yc < ORIG_Y_CELL + BMP_H);
    c       = xc - ORIG_X_CELL;
    r       = yc - ORIG_Y_CELL;
    col     = c + 32'(scroll_offset);
    if (col >= BMP_W) col = col - BMP_W;
    idx     = r * BMP_W + col;
    bmp_bit = 1'(BITMAP >> idx);
  end

`ifdef TEXT_OVERLAY_BLINK_EN
  assign pixel_on = in_win & bmp_bit & ~blink_phase;
`else
  assign pixel_on = in_win & bmp_bit;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overlay_active <= 1'b0;
    else        overlay_active <= pixel_on;
  end

endmodule

// File: tb/tb_text_overlay_marquee.sv
// Self-checking bench for text_overlay_marquee against a frame-count based reference model.
module tb_text_overlay_marquee;

  localparam int unsigned BMP_W = 46;
  localparam int unsigned BMP_H = 9;
  localparam int unsigned OX    = 18;
  localparam int unsigned OY    = 12;
  localparam int unsigned CL2   = 3;
  localparam int unsigned WIN_W = 40;
  localparam int unsigned DIV   = 2;
  localparam int unsigned PAUSE = 3;
  localparam int unsigned BLINK = 2;
  localparam int          CYC   = PAUSE + BMP_W * DIV;

  function automatic logic [BMP_W*BMP_H-1:0] make_bmp();
    logic [31:0]              s;
    logic [BMP_W*BMP_H-1:0]   b;
    s = 32'h1ace_b00c;
    b = '0;
    for (int i = 0; i < BMP_W * BMP_H; i++) begin
      s = s ^ (s << 13);
      s = s ^ (s >> 17);
      s = s ^ (s << 5);
      b[i] = s[3];
    end
    return b;
  endfunction

  localparam logic [BMP_W*BMP_H-1:0] BMP = make_bmp();

  logic       clk, rst_n, frame_start, scroll_en;
  logic [9:0] x, y;
  logic       overlay_active, scroll_wrap;
  logic [5:0] scroll_offset;

  text_overlay_marquee #(
    .BMP_W(BMP_W), .BMP_H(BMP_H), .BITMAP(BMP), .ORIG_X_CELL(OX), .ORIG_Y_CELL(OY),
    .CELL_LOG2(CL2), .WIN_W(WIN_W), .SCROLL_DIV(DIV), .PAUSE_FRAMES(PAUSE), .BLINK_FRAMES(BLINK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .scroll_en(scroll_en),
    .x(x), .y(y), .overlay_active(overlay_active),
    .scroll_offset(scroll_offset), .scroll_wrap(scroll_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int n_steps = 0;   // frames counted with scroll_en high since last reset

  // Offset as a function of counted frames: each pass is PAUSE frames at 0, then DIV frames per column.
  function automatic int model_offset(input int n);
    int k;
    k = n % CYC;
    return (k < PAUSE) ? 0 : (k - PAUSE) / DIV;
  endfunction

  function automatic logic model_phase(input int n);
`ifdef TEXT_OVERLAY_BLINK_EN
    return ((n / BLINK) % 2) == 1;
`else
    return (n < 0);
`endif
  endfunction

  function automatic logic model_pixel(input int px, input int py, input int off, input logic ph);
    int xc, yc, colm, idx;
    logic [BMP_W*BMP_H-1:0] b;
    b  = BMP;
    xc = px >> CL2;
    yc = py >> CL2;
    if (xc < OX || xc >= OX + WIN_W || yc < OY || yc >= OY + BMP_H) return 1'b0;
    colm = (xc - OX + off) % BMP_W;
    idx  = (yc - OY) * BMP_W + colm;
    return b[idx] & ~ph;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pix(input string tag, input int px, input int py);
    x = 10'(px);
    y = 10'(py);
    tick();
    check(tag, 32'(overlay_active),
          32'(model_pixel(px, py, model_offset(n_steps), model_phase(n_steps))));
  endtask

  task automatic frame(input logic en);
    frame_start = 1'b1;
    scroll_en   = en;
    tick();
    frame_start = 1'b0;
    if (en) n_steps++;
    check("offset", 32'(scroll_offset), 32'(model_offset(n_steps)));
    check("wrap", 32'(scroll_wrap), 32'(en && n_steps > 0 && n_steps % CYC == 0));
    tick();
    check("wrap_clear", 32'(scroll_wrap), 32'd0);
  endtask

  task automatic random_pixels(input int count);
    for (int i = 0; i < count; i++)
      pix("rand_pixel", int'($urandom_range(120, 500)), int'($urandom_range(88, 180)));
  endtask

  // Advance enabled frames until the first frame showing offset 'target' during the scroll phase.
  task automatic run_to(input int target);
    int guard;
    guard = 0;
    do begin
      frame(1'b1);
      guard++;
      if (guard % 9 == 0) random_pixels(1);
    end while (!(model_offset(n_steps) == target && (n_steps % CYC) >= PAUSE) && guard < 400);
    check("run_to_budget", 32'(guard < 400), 32'd1);
  endtask

  logic [BMP_W*BMP_H-1:0] bv;
  int lit_x;

  initial begin
    bv          = BMP;
    rst_n       = 1'b0;
    frame_start = 1'b0;
    scroll_en   = 1'b0;
    x           = 10'd144;
    y           = 10'd96;
    tick();
    tick();
    check("reset_active", 32'(overlay_active), 32'd0);
    check("reset_offset", 32'(scroll_offset), 32'd0);
    check("reset_wrap", 32'(scroll_wrap), 32'd0);
    rst_n = 1'b1;

    // Static window edges with scrolling frozen
    x = 10'd144; y = 10'd96; tick();
    check("static_b0", 32'(overlay_active), 32'(bv[0]));
    pix("left_out", 143, 96);
    pix("bottom_out", 144, 168);
    pix("bottom_in", 151, 167);
    pix("top_out", 150, 95);
    pix("right_in", 463, 100);
    pix("right_out", 464, 100);
    pix("far_out", 1000, 1000);
    random_pixels(20);

    // frame_start while disabled is ignored
    frame(1'b0);
    frame(1'b0);

    // Pause then first scroll step
    for (int i = 0; i < PAUSE + DIV; i++) frame(1'b1);
    check("first_step", 32'(scroll_offset), 32'd1);

    // Freeze with div_cnt mid-count at offset 17
    run_to(17);
    frame(1'b1);
    for (int i = 0; i < 5; i++) frame(1'b0);
    check("frozen17", 32'(scroll_offset), 32'd17);
    frame(1'b1);
    check("resume18", 32'(scroll_offset), 32'd18);

    // Column wrap inside the bitmap lookup
    run_to(40);
    random_pixels(10);
    x = 10'((OX + 10) * 8 + 3);
    y = 10'((OY + 4) * 8 + 5);
    tick();
    check("colwrap_direct", 32'(overlay_active),
          32'(bv[4*BMP_W+4] & ~model_phase(n_steps)));

    // Offset wrap back to 0 and into the next pause
    run_to(45);
    while (n_steps % CYC != 0) frame(1'b1);
    check("wrapped_offset", 32'(scroll_offset), 32'd0);
    random_pixels(10);

    // Async reset mid-pass with a lit pixel selected
    run_to(17);
    lit_x = 144;
    for (int c = 0; c < int'(WIN_W); c++)
      if (model_pixel((OX + c) * 8, 96, 17, 1'b0)) lit_x = (OX + c) * 8;
    pix("prereset_pixel", lit_x, 96);
    #2 rst_n = 1'b0;
    #1;
    check("async_offset", 32'(scroll_offset), 32'd0);
    check("async_active", 32'(overlay_active), 32'd0);
    check("async_wrap", 32'(scroll_wrap), 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    n_steps = 0;
    for (int i = 0; i < 8; i++) begin
      frame(1'b1);
      random_pixels(2);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
